// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle main control unit:
// opcodes, ALUOp and pc_src codes, the FSM state enum and the opcode classifier.
package mc_ctrl_pkg;

    localparam logic [3:0] OP_LD    = 4'b0000;
    localparam logic [3:0] OP_ST    = 4'b0001;
    localparam logic [3:0] OP_R_LO  = 4'b0010;
    localparam logic [3:0] OP_R_HI  = 4'b1001;
    localparam logic [3:0] OP_BEQ   = 4'b1011;
    localparam logic [3:0] OP_BNE   = 4'b1100;
    localparam logic [3:0] OP_JMP   = 4'b1101;

    localparam logic [1:0] ALUOP_FUNC = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_ADD  = 2'b10;

    localparam logic [1:0] PC_SEQ    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWR  = 4'd5,
        S_WBLD   = 4'd6,
        S_EXEC   = 4'd7,
        S_WBR    = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_HALT   = 4'd11
    } state_t;

    typedef enum logic [2:0] {
        C_LD,
        C_ST,
        C_RTYPE,
        C_BEQ,
        C_BNE,
        C_JMP,
        C_ILL
    } op_class_t;

    // Map a 4-bit opcode onto its instruction class.
    function automatic op_class_t op_class(input logic [3:0] op);
        op_class_t c;
        if (op == OP_LD) begin
            c = C_LD;
        end else if (op == OP_ST) begin
            c = C_ST;
        end else if (op >= OP_R_LO && op <= OP_R_HI) begin
            c = C_RTYPE;
        end else if (op == OP_BEQ) begin
            c = C_BEQ;
        end else if (op == OP_BNE) begin
            c = C_BNE;
        end else if (op == OP_JMP) begin
            c = C_JMP;
        end else begin
            c = C_ILL;
        end
        return c;
    endfunction

endpackage

// File: rtl/mc_control_fsm.sv
// Multi-cycle main control FSM for the 16-bit RISC core.
// Sequences each instruction and guards memory handshakes with a timeout.
module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int TMR_W       = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] opcode,
    input  logic       zero,
    input  logic       imem_ready,
    input  logic       dmem_ready,
    output logic [1:0] alu_op,
    output logic       alu_src,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       imem_read,
    output logic       dmem_read,
    output logic       dmem_write,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       halted,
    output logic       bus_error
);

    localparam logic [TMR_W-1:0] TMO = TMR_W'(MEM_TIMEOUT);

    state_t           state;
    state_t           state_nxt;
    logic [TMR_W-1:0] wait_cnt;
    logic             stall;
    logic             timeout;
    op_class_t        cls;

    assign cls = op_class(opcode);

    // A memory-wait state whose handshake has not completed this cycle.
    always_comb begin
        stall = 1'b0;
        unique case (state)
            S_FETCH: stall = ~imem_ready;
            S_MEMRD: stall = ~dmem_ready;
            S_MEMWR: stall = ~dmem_ready;
            default: stall = 1'b0;
        endcase
    end

    assign timeout = stall && (wait_cnt == TMO);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Wait counter: restarts on each state change, counts stalled cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state_nxt != state) begin
            wait_cnt <= '0;
        end else if (stall) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Sticky bus error, raised on the edge that enters HALT by timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_error <= 1'b0;
        end else if (timeout) begin
            bus_error <= 1'b1;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: state_nxt = S_FETCH;
            S_FETCH: begin
                if (imem_ready) begin
                    state_nxt = S_DECODE;
                end else if (timeout) begin
                    state_nxt = S_HALT;
                end
            end
            S_DECODE: begin
                unique case (cls)
                    C_LD, C_ST:   state_nxt = S_MEMADR;
                    C_RTYPE:      state_nxt = S_EXEC;
                    C_BEQ, C_BNE: state_nxt = S_BRANCH;
                    C_JMP:        state_nxt = S_JUMP;
                    default:      state_nxt = S_HALT;
                endcase
            end
            S_MEMADR: begin
                state_nxt = (cls == C_LD) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                if (dmem_ready) begin
                    state_nxt = S_WBLD;
                end else if (timeout) begin
                    state_nxt = S_HALT;
                end
            end
            S_MEMWR: begin
                if (dmem_ready) begin
                    state_nxt = S_FETCH;
                end else if (timeout) begin
                    state_nxt = S_HALT;
                end
            end
            S_WBLD:   state_nxt = S_FETCH;
            S_EXEC:   state_nxt = S_WBR;
            S_WBR:    state_nxt = S_FETCH;
            S_BRANCH: state_nxt = S_FETCH;
            S_JUMP:   state_nxt = S_FETCH;
            S_HALT:   state_nxt = S_HALT;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Output decode from state; FETCH and BRANCH qualify pc/ir writes.
    always_comb begin
        alu_op     = ALUOP_FUNC;
        alu_src    = 1'b0;
        reg_dst    = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        imem_read  = 1'b0;
        dmem_read  = 1'b0;
        dmem_write = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PC_SEQ;
        halted     = 1'b0;
        unique case (state)
            S_FETCH: begin
                imem_read = 1'b1;
                ir_write  = imem_ready;
                pc_write  = imem_ready;
            end
            S_DECODE, S_MEMADR: begin
                alu_op  = ALUOP_ADD;
                alu_src = 1'b1;
            end
            S_MEMRD: dmem_read = 1'b1;
            S_MEMWR: dmem_write = 1'b1;
            S_WBLD: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_WBR: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_op   = ALUOP_SUB;
                pc_src   = PC_BRANCH;
                pc_write = (cls == C_BEQ) ? zero : ~zero;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                pc_src   = PC_JUMP;
            end
            S_HALT: halted = 1'b1;
            default: begin
                alu_op = ALUOP_FUNC;
            end
        endcase
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: directed cases plus random
// instruction streams checked cycle by cycle against a per-instruction model.
module tb_mc_control_fsm;

    localparam int TMO = 15;

    typedef struct packed {
        logic [1:0] alu_op;
        logic       alu_src;
        logic       reg_dst;
        logic       reg_write;
        logic       mem_to_reg;
        logic       imem_read;
        logic       dmem_read;
        logic       dmem_write;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       halted;
        logic       bus_error;
    } outs_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] opcode = 4'd0;
    logic       zero = 1'b0;
    logic       imem_ready = 1'b0;
    logic       dmem_ready = 1'b0;
    logic [1:0] alu_op;
    logic       alu_src;
    logic       reg_dst;
    logic       reg_write;
    logic       mem_to_reg;
    logic       imem_read;
    logic       dmem_read;
    logic       dmem_write;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       halted;
    logic       bus_error;

    outs_t obs;
    int    tests = 0;
    int    fails = 0;

    mc_control_fsm #(.MEM_TIMEOUT(TMO), .TMR_W(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .alu_op(alu_op), .alu_src(alu_src), .reg_dst(reg_dst),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg),
        .imem_read(imem_read), .dmem_read(dmem_read),
        .dmem_write(dmem_write), .ir_write(ir_write),
        .pc_write(pc_write), .pc_src(pc_src),
        .halted(halted), .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    assign obs = {alu_op, alu_src, reg_dst, reg_write, mem_to_reg,
                  imem_read, dmem_read, dmem_write, ir_write, pc_write,
                  pc_src, halted, bus_error};

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic chk(input string tag, input outs_t e);
        tests++;
        assert (obs === e) else begin
            fails++;
            $error("FAIL %s got=%h exp=%h", tag, obs, e);
        end
    endtask

    // Advance to the next falling edge, drive inputs, let comb settle.
    task automatic tick(input logic ir, input logic dr, input logic z);
        @(negedge clk);
        imem_ready = ir;
        dmem_ready = dr;
        zero = z;
        #1;
    endtask

    task automatic do_reset();
        outs_t e;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        e = '0;
        chk("idle", e);
    endtask

    // Reference behaviour of one instruction, cycle by cycle.
    task automatic run_instr(input logic [3:0] op, input int iw,
                             input int dw, input logic z);
        outs_t e;
        int    o;
        o = int'(op);
        opcode = op;
        for (int k = 0; k <= iw; k++) begin
            tick(k == iw, rb(), rb());
            e = '0;
            e.imem_read = 1'b1;
            e.ir_write = (k == iw);
            e.pc_write = (k == iw);
            chk("fetch", e);
        end
        tick(rb(), rb(), rb());
        e = '0;
        e.alu_op = 2'b10;
        e.alu_src = 1'b1;
        chk("decode", e);
        if (o <= 1) begin
            tick(rb(), rb(), rb());
            chk("memadr", e);
            for (int k = 0; k <= dw; k++) begin
                tick(rb(), k == dw, rb());
                e = '0;
                if (o == 0) e.dmem_read = 1'b1;
                else e.dmem_write = 1'b1;
                chk(o == 0 ? "memrd" : "memwr", e);
            end
            if (o == 0) begin
                tick(rb(), rb(), rb());
                e = '0;
                e.reg_write = 1'b1;
                e.mem_to_reg = 1'b1;
                chk("wbld", e);
            end
        end else if (o <= 9) begin
            tick(rb(), rb(), rb());
            e = '0;
            chk("exec", e);
            tick(rb(), rb(), rb());
            e.reg_write = 1'b1;
            e.reg_dst = 1'b1;
            chk("wbr", e);
        end else if (o == 11 || o == 12) begin
            tick(rb(), rb(), z);
            e = '0;
            e.alu_op = 2'b01;
            e.pc_src = 2'b01;
            e.pc_write = (o == 11) ? z : ~z;
            chk(o == 11 ? "beq" : "bne", e);
        end else if (o == 13) begin
            tick(rb(), rb(), rb());
            e = '0;
            e.pc_write = 1'b1;
            e.pc_src = 2'b10;
            chk("jmp", e);
        end else begin
            e = '0;
            e.halted = 1'b1;
            for (int k = 0; k < 20; k++) begin
                tick(rb(), rb(), rb());
                chk("ill_halt", e);
            end
            do_reset();
        end
    endtask

    initial begin
        outs_t e;
        do_reset();
        run_instr(4'b0010, 0, 0, 1'b0);
        run_instr(4'b0010, 0, 0, 1'b0);
        run_instr(4'b0000, 0, 3, 1'b0);
        run_instr(4'b0001, 0, 0, 1'b0);
        run_instr(4'b1011, 0, 0, 1'b1);
        run_instr(4'b1011, 0, 0, 1'b0);
        run_instr(4'b1100, 0, 0, 1'b1);
        run_instr(4'b1100, 0, 0, 1'b0);
        run_instr(4'b1101, 2, 0, 1'b0);
        run_instr(4'b1110, 0, 0, 1'b0);

        opcode = 4'b0010;
        for (int k = 0; k <= TMO; k++) begin
            tick(1'b0, rb(), rb());
            e = '0;
            e.imem_read = 1'b1;
            chk("to_fetch", e);
        end
        e = '0;
        e.halted = 1'b1;
        e.bus_error = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick(rb(), rb(), rb());
            chk("to_halt", e);
        end
        do_reset();
        run_instr(4'b0010, TMO, 0, 1'b0);
        run_instr(4'b0000, 1, TMO, 1'b0);

        opcode = 4'b0001;
        tick(1'b1, rb(), rb());
        e = '0;
        e.imem_read = 1'b1;
        e.ir_write = 1'b1;
        e.pc_write = 1'b1;
        chk("rw_fetch", e);
        tick(rb(), rb(), rb());
        e = '0;
        e.alu_op = 2'b10;
        e.alu_src = 1'b1;
        chk("rw_decode", e);
        tick(rb(), rb(), rb());
        chk("rw_memadr", e);
        tick(rb(), 1'b0, rb());
        e = '0;
        e.dmem_write = 1'b1;
        chk("rw_memwr", e);
        rst = 1'b1;
        tick(rb(), rb(), rb());
        e = '0;
        chk("rw_abort", e);
        rst = 1'b0;
        run_instr(4'b0011, 0, 0, 1'b0);

        for (int n = 0; n < 80; n++) begin
            int iw;
            int dw;
            iw = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, TMO))
                                             : int'($urandom_range(0, 2));
            dw = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, TMO))
                                             : int'($urandom_range(0, 2));
            run_instr(4'($urandom_range(0, 15)), iw, dw, rb());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
